alu_serial_seq: RTL and testbench

Bit-serial multi-cycle ALU engine. It accepts WIDTH-bit operands and an opcode in one handshake, then pushes one bit per clock through a single combinational one-bit ALU slice, LSB first. A registered carry links the bits, and the engine presents a registered result with status flags. It sits between the datapath control and the register file in small-area datapath builds.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_bit_slice.sv | 25 ++
 rtl/alu_serial_seq.sv | 122 ++++++++++++
 tb/tb_alu_serial_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Subtract and compare both run a + ~b + 1 through the adder.
    function automatic logic needs_invert(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND / OR / full-adder sum / pass-through of 'less'.
// The carry is always the full-adder carry, regardless of sel.
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic       less,
    input  logic [1:0] sel,
    output logic       result,
    output logic       carry_out
);

    always_comb begin
        result = 1'b0;
        case (sel)
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = a ^ b ^ carry_in;
            default: result = less;
        endcase
    end

    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: captures operands on start, feeds one bit per clock (LSB
// first) through a single alu_bit_slice, then pulses done with result/flags.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             op_err
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_q;
    logic [CW-1:0]    count;
    logic             carry_q;

    logic             b_bit, slice_res, slice_cout, last, slt_bit;
    logic [1:0]       sel;
    logic [WIDTH-1:0] result_shift, result_fin;

    assign b_bit = b_sh[0] ^ needs_invert(op_q);
    // SUB shares the adder path; the '11' leg of the slice is reserved for SLT.
    assign sel   = (op_q == OP_SUB) ? 2'b10 : op_q[1:0];
    assign last  = (count == CW'(WIDTH - 1));

    alu_bit_slice u_slice (
        .a         (a_sh[0]),
        .b         (b_bit),
        .carry_in  (carry_q),
        .less      (1'b0),
        .sel       (sel),
        .result    (slice_res),
        .carry_out (slice_cout)
    );

    // sum_msb ^ overflow, where overflow = carry into MSB ^ carry out of MSB.
    assign slt_bit      = (a_sh[0] ^ b_bit ^ carry_q) ^ (carry_q ^ slice_cout);
    assign result_shift = {slice_res, result[WIDTH-1:1]};
    assign result_fin   = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : result_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = is_valid_op(alu_op) ? SHIFT : DONE;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= '0;
            count     <= '0;
            carry_q   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    op_q    <= alu_op;
                    count   <= '0;
                    carry_q <= needs_invert(alu_op);
                    if (!is_valid_op(alu_op)) begin
                        result    <= '0;
                        carry_out <= 1'b0;
                        zero      <= 1'b1;
                        op_err    <= 1'b1;
                    end else begin
                        op_err    <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= slice_cout;
                    count   <= count + 1'b1;
                    if (last) begin
                        result    <= result_fin;
                        zero      <= (result_fin == '0);
                        carry_out <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? slice_cout : 1'b0;
                    end else begin
                        result    <= result_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq: arithmetic model with cycle-accurate
// busy/done timeline, plus literal expectations for each directed vector.
module tb_alu_serial_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   alu_op = 3'b000;
    logic         busy, done, carry_out, zero, op_err;
    logic [W-1:0] result;

    int checks = 0;
    int passes = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .alu_op(alu_op),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .zero(zero), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference arithmetic straight from the opcode definitions.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                         output logic [W-1:0] r, output logic c, output logic bad);
        logic [W:0] t;
        r = '0; c = 1'b0; bad = 1'b0;
        case (op)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin t = {1'b0, x} + {1'b0, y}; r = t[W-1:0]; c = t[W]; end
            3'b011: begin t = {1'b0, x} + {1'b0, ~y} + 1; r = t[W-1:0]; c = t[W]; end
            3'b111: r = ($signed(x) < $signed(y)) ? 1 : 0;
            default: bad = 1'b1;
        endcase
    endtask

    // Timeline model: cyc counts clock edges; an op accepted at an edge is
    // busy from the next cycle for W cycles, then done for one cycle.
    int           cyc = 0;
    int           m_acc = 0, m_end = 0;
    bit           m_active = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_c = 1'b0, m_bad = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
        end else if (start && (!m_active || cyc > m_end)) begin
            model(a, b, alu_op, m_res, m_c, m_bad);
            m_active = 1'b1;
            m_acc    = cyc + 1;
            m_end    = m_bad ? m_acc : m_acc + W;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic e_busy, e_done;
            e_busy = m_active && !m_bad && cyc >= m_acc && cyc < m_end;
            e_done = m_active && cyc == m_end;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            if (e_done) begin
                chk("model_result", result, m_res);
                chk("model_carry", carry_out, m_c);
                chk("model_zero", zero, m_res == '0);
                chk("model_op_err", op_err, m_bad);
            end
        end
    end

    // Issue one op and wait for done; optionally re-pulse start (with junk
    // operands) on wait cycle 'repulse' to check it is ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                          input logic [W-1:0] lr, input logic lc, input logic lz, input logic le,
                          input int repulse);
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; alu_op = top;
        for (int k = 1; k <= W + 4 && !seen; k++) begin
            @(negedge clk);
            if (k == repulse) begin
                start = 1'b1; a = ~ta; b = 32'h5555_5555; alu_op = 3'b001;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1'b1);
        chk("lit_result", result, lr);
        chk("lit_carry", carry_out, lc);
        chk("lit_zero", zero, lz);
        chk("lit_op_err", op_err, le);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry_out, zero, op_err}, 0);
        reset = 1'b0;

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 0, 0, 0, 0);
        run_op(32'd5, 32'd7, 3'b011, 32'hFFFF_FFFE, 0, 0, 0, 0);
        run_op(32'd7, 32'd7, 3'b011, 32'h0, 1, 1, 0, 0);
        run_op(32'hFFFF_FFFF, 32'h1, 3'b111, 32'h1, 0, 0, 0, 0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0, 0, 1, 0, 0);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h1, 0, 0, 0, 0);
        run_op(32'hF0F0_1234, 32'h0FF0_FF00, 3'b000, 32'h00F0_1200, 0, 0, 0, 0);
        run_op(32'hF0F0_1234, 32'h0FF0_FF00, 3'b001, 32'hFFF0_FF34, 0, 0, 0, 0);
        run_op(32'h1234_5678, 32'h1, 3'b101, 32'h0, 0, 1, 1, 0);
        run_op(32'd2, 32'd3, 3'b010, 32'd5, 0, 0, 0, 0);
        run_op(32'h1, 32'h1, 3'b110, 32'h0, 0, 1, 1, 0);
        run_op(32'h1234_5678, 32'h1111_1111, 3'b010, 32'h2345_6789, 0, 0, 0, 5);

        // Reset in the middle of an op: outputs clear at once, no done.
        @(negedge clk);
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; alu_op = 3'b010;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {carry_out, zero, op_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 1, 1, 0, 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
